vector_add_acc: RTL and testbench

VECTOR_ADD_ACC -- requirements
Module: vector_add_acc

---
 rtl/vector_add_acc_pkg.sv | 31 +++
 rtl/vector_lane_adder.sv | 24 ++
 rtl/vector_add_acc.sv | 237 +++++++++++++++++++++++
 tb/tb_vector_add_acc.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_add_acc_pkg.sv
// Shared definitions for vector_add_acc: controller state encoding, the AXI4
// constants it drives or compares against, and the burst sizing helper.
package vector_add_acc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrAddr,
        StWrData,
        StWrResp,
        StDone
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_VAL  = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Beats in the next read burst: bounded by what is left, the burst
    // ceiling and the distance to the next 4 KiB page.
    function automatic logic [4:0] burst_beats(input logic [31:0] remaining,
                                               input logic [4:0]  max_burst,
                                               input logic [12:0] to_boundary);
        logic [31:0] b;
        b = remaining;
        if (b > 32'(max_burst)) b = 32'(max_burst);
        if (b > 32'(to_boundary)) b = 32'(to_boundary);
        return b[4:0];
    endfunction

endpackage

// File: rtl/vector_lane_adder.sv
// Combinational lane-wise adder.
//   i_a, i_b : DATA_W-bit operands, split into DATA_W/LANE_W lanes
//   o_sum    : per-lane sum, wrapping (SAT=0) or clamped to all-ones (SAT=1)
module vector_lane_adder #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned SAT    = 0
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum
);

    localparam int unsigned LANES = DATA_W / LANE_W;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W:0] w_s;
        assign w_s = {1'b0, i_a[g*LANE_W +: LANE_W]} + {1'b0, i_b[g*LANE_W +: LANE_W]};
        // Carry out of the lane means overflow; clamp only when saturating.
        assign o_sum[g*LANE_W +: LANE_W] = (w_s[LANE_W] && (SAT != 0)) ?
                                           {LANE_W{1'b1}} : w_s[LANE_W-1:0];
    end

endmodule

// File: rtl/vector_add_acc.sv
// Vector add-accumulate engine. Reads len_read bytes from addr_read over AXI4
// in INCR bursts (one outstanding, never crossing a 4 KiB page), sums every
// beat lane-wise into one DATA_W accumulator, then writes the accumulator as a
// single beat to addr_write (byte strobes cover len_write bytes).
//   clock, reset          : single clock, synchronous active-high reset
//   io_infor_in_*         : command handshake + read/write address and length
//   io_mem_interface_ar/r : AXI4 read address / read data channels
//   io_mem_interface_aw/w/b : AXI4 write address / data / response channels
//   io_infor_out_*        : completion, bits=1 success, 0 if any AXI error
module vector_add_acc
    import vector_add_acc_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned LANE_W    = 32,
    parameter int unsigned ADDR_W    = 33,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned SAT       = 0,
    parameter int unsigned AXI_ID    = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_infor_in_valid,
    output logic                io_infor_in_ready,
    input  logic [ADDR_W-1:0]   io_infor_in_bits_addr_read,
    input  logic [31:0]         io_infor_in_bits_len_read,
    input  logic [ADDR_W-1:0]   io_infor_in_bits_addr_write,
    input  logic [31:0]         io_infor_in_bits_len_write,
    output logic                io_mem_interface_ar_valid,
    input  logic                io_mem_interface_ar_ready,
    output logic [ADDR_W-1:0]   io_mem_interface_ar_addr,
    output logic [3:0]          io_mem_interface_ar_len,
    output logic [2:0]          io_mem_interface_ar_size,
    output logic [1:0]          io_mem_interface_ar_burst,
    output logic [5:0]          io_mem_interface_ar_id,
    output logic [3:0]          io_mem_interface_ar_cache,
    output logic                io_mem_interface_ar_lock,
    output logic [2:0]          io_mem_interface_ar_prot,
    output logic [3:0]          io_mem_interface_ar_qos,
    output logic [3:0]          io_mem_interface_ar_region,
    output logic                io_mem_interface_aw_valid,
    input  logic                io_mem_interface_aw_ready,
    output logic [ADDR_W-1:0]   io_mem_interface_aw_addr,
    output logic [3:0]          io_mem_interface_aw_len,
    output logic [2:0]          io_mem_interface_aw_size,
    output logic [1:0]          io_mem_interface_aw_burst,
    output logic [5:0]          io_mem_interface_aw_id,
    output logic [3:0]          io_mem_interface_aw_cache,
    output logic                io_mem_interface_aw_lock,
    output logic [2:0]          io_mem_interface_aw_prot,
    output logic [3:0]          io_mem_interface_aw_qos,
    output logic [3:0]          io_mem_interface_aw_region,
    output logic                io_mem_interface_w_valid,
    input  logic                io_mem_interface_w_ready,
    output logic [DATA_W-1:0]   io_mem_interface_w_data,
    output logic [DATA_W/8-1:0] io_mem_interface_w_strb,
    output logic                io_mem_interface_w_last,
    input  logic                io_mem_interface_r_valid,
    output logic                io_mem_interface_r_ready,
    input  logic [DATA_W-1:0]   io_mem_interface_r_data,
    input  logic                io_mem_interface_r_last,
    input  logic [1:0]          io_mem_interface_r_resp,
    input  logic [5:0]          io_mem_interface_r_id,
    input  logic                io_mem_interface_b_valid,
    output logic                io_mem_interface_b_ready,
    input  logic [1:0]          io_mem_interface_b_resp,
    input  logic [5:0]          io_mem_interface_b_id,
    output logic                io_infor_out_valid,
    input  logic                io_infor_out_ready,
    output logic                io_infor_out_bits
);

    localparam int unsigned BYTES      = DATA_W / 8;
    localparam int unsigned LOG2_BYTES = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << LOG2_BYTES;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_beats_left;
    logic [4:0]          r_burst_len;
    logic [4:0]          r_beat_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [BYTES-1:0]    r_strb;
    logic                r_err;
    logic                r_skip_wr;

    logic [32:0]         w_len_round;
    logic [31:0]         w_in_beats;
    logic [12:0]         w_page_left;
    logic [12:0]         w_to_boundary;
    logic [4:0]          w_burst;
    logic [4:0]          w_beat_next;
    logic [BYTES-1:0]    w_strb;
    logic [DATA_W-1:0]   w_sum;
    logic                w_unused;

    assign w_len_round   = {1'b0, io_infor_in_bits_len_read} + 33'(BYTES - 1);
    assign w_in_beats    = 32'(w_len_round >> LOG2_BYTES);
    assign w_page_left   = 13'd4096 - {1'b0, r_rd_addr[11:0]};
    assign w_to_boundary = w_page_left >> LOG2_BYTES;
    assign w_burst       = burst_beats(r_beats_left, 5'(MAX_BURST), w_to_boundary);
    // Saturating so a runaway burst without r_last cannot wrap back to a match.
    assign w_beat_next   = (r_beat_cnt == 5'h1f) ? r_beat_cnt : r_beat_cnt + 5'd1;
    assign w_unused      = ^{io_mem_interface_r_id, io_mem_interface_b_id};

    always_comb begin
        w_strb = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_strb[i] = (32'(i) < io_infor_in_bits_len_write);
        end
    end

    vector_lane_adder #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .SAT    (SAT)
    ) u_lane_adder (
        .i_a   (r_acc),
        .i_b   (io_mem_interface_r_data),
        .o_sum (w_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_beats_left <= '0;
            r_burst_len  <= '0;
            r_beat_cnt   <= '0;
            r_acc        <= '0;
            r_strb       <= '0;
            r_err        <= 1'b0;
            r_skip_wr    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_infor_in_valid) begin
                        r_rd_addr    <= io_infor_in_bits_addr_read & ADDR_MASK;
                        r_wr_addr    <= io_infor_in_bits_addr_write & ADDR_MASK;
                        r_beats_left <= w_in_beats;
                        r_strb       <= w_strb;
                        r_skip_wr    <= (io_infor_in_bits_len_write == 32'd0);
                        r_acc        <= '0;
                        r_err        <= 1'b0;
                        if (w_in_beats != 32'd0) begin
                            r_state <= StRdAddr;
                        end else if (io_infor_in_bits_len_write == 32'd0) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StWrAddr;
                        end
                    end
                end
                StRdAddr: begin
                    if (io_mem_interface_ar_ready) begin
                        r_burst_len <= w_burst;
                        r_beat_cnt  <= '0;
                        r_state     <= StRdData;
                    end
                end
                StRdData: begin
                    if (io_mem_interface_r_valid) begin
                        r_acc      <= w_sum;
                        r_beat_cnt <= w_beat_next;
                        if (io_mem_interface_r_resp != AXI_RESP_OKAY) r_err <= 1'b1;
                        if (io_mem_interface_r_last) begin
                            if (w_beat_next != r_burst_len) r_err <= 1'b1;
                            // Advance by the planned burst so addressing stays page-safe.
                            r_rd_addr    <= r_rd_addr + (ADDR_W'(r_burst_len) << LOG2_BYTES);
                            r_beats_left <= r_beats_left - 32'(r_burst_len);
                            if (r_beats_left != 32'(r_burst_len)) begin
                                r_state <= StRdAddr;
                            end else if (r_skip_wr) begin
                                r_state <= StDone;
                            end else begin
                                r_state <= StWrAddr;
                            end
                        end else if (w_beat_next >= r_burst_len) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StWrAddr: begin
                    if (io_mem_interface_aw_ready) r_state <= StWrData;
                end
                StWrData: begin
                    if (io_mem_interface_w_ready) r_state <= StWrResp;
                end
                StWrResp: begin
                    if (io_mem_interface_b_valid) begin
                        if (io_mem_interface_b_resp != AXI_RESP_OKAY) r_err <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (io_infor_out_ready) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // All outputs decode registered state only; no input-to-output paths.
    assign io_infor_in_ready          = (r_state == StIdle);
    assign io_mem_interface_ar_valid  = (r_state == StRdAddr);
    assign io_mem_interface_ar_addr   = r_rd_addr;
    assign io_mem_interface_ar_len    = 4'(w_burst - 5'd1);
    assign io_mem_interface_ar_size   = 3'(LOG2_BYTES);
    assign io_mem_interface_ar_burst  = AXI_BURST_INCR;
    assign io_mem_interface_ar_id     = 6'(AXI_ID);
    assign io_mem_interface_ar_cache  = AXI_CACHE_VAL;
    assign io_mem_interface_ar_lock   = 1'b0;
    assign io_mem_interface_ar_prot   = 3'd0;
    assign io_mem_interface_ar_qos    = 4'd0;
    assign io_mem_interface_ar_region = 4'd0;
    assign io_mem_interface_aw_valid  = (r_state == StWrAddr);
    assign io_mem_interface_aw_addr   = r_wr_addr;
    assign io_mem_interface_aw_len    = 4'd0;
    assign io_mem_interface_aw_size   = 3'(LOG2_BYTES);
    assign io_mem_interface_aw_burst  = AXI_BURST_INCR;
    assign io_mem_interface_aw_id     = 6'(AXI_ID);
    assign io_mem_interface_aw_cache  = AXI_CACHE_VAL;
    assign io_mem_interface_aw_lock   = 1'b0;
    assign io_mem_interface_aw_prot   = 3'd0;
    assign io_mem_interface_aw_qos    = 4'd0;
    assign io_mem_interface_aw_region = 4'd0;
    assign io_mem_interface_w_valid   = (r_state == StWrData);
    assign io_mem_interface_w_data    = r_acc;
    assign io_mem_interface_w_strb    = r_strb;
    assign io_mem_interface_w_last    = 1'b1;
    assign io_mem_interface_r_ready   = (r_state == StRdData);
    assign io_mem_interface_b_ready   = (r_state == StWrResp);
    assign io_infor_out_valid         = (r_state == StDone);
    assign io_infor_out_bits          = ~r_err;

endmodule

// File: tb/tb_vector_add_acc.sv
// Bench for vector_add_acc: a wrapping (SAT=0) and a saturating (SAT=1) copy
// share every input; the bench acts as AXI slave and checks addresses, burst
// split, write data/strobes and completion status against its own model.
module tb_vector_add_acc;

    localparam int LIMIT = 60;

    logic         clock = 1'b0;
    logic         reset;
    always #5 clock = ~clock;

    logic         in_valid, in_ready;
    logic [32:0]  addr_read, addr_write;
    logic [31:0]  len_read, len_write;
    logic         ar_valid, ar_ready, ar_lock;
    logic [32:0]  ar_addr;
    logic [3:0]   ar_len, ar_cache, ar_qos, ar_region;
    logic [2:0]   ar_size, ar_prot;
    logic [1:0]   ar_burst;
    logic [5:0]   ar_id;
    logic         aw_valid, aw_ready, aw_lock;
    logic [32:0]  aw_addr;
    logic [3:0]   aw_len, aw_cache, aw_qos, aw_region;
    logic [2:0]   aw_size, aw_prot;
    logic [1:0]   aw_burst;
    logic [5:0]   aw_id;
    logic         w_valid, w_ready, w_last;
    logic [255:0] w_data;
    logic [31:0]  w_strb;
    logic         r_valid, r_ready, r_last;
    logic [255:0] r_data;
    logic [1:0]   r_resp, b_resp;
    logic         b_valid, b_ready;
    logic         out_valid, out_ready, out_bits;

    logic [255:0] sat_w_data;
    logic         sat_out_bits;
    logic         unused_sat_in_ready, unused_sat_ar_valid, unused_sat_ar_lock;
    logic         unused_sat_aw_valid, unused_sat_aw_lock, unused_sat_w_valid;
    logic         unused_sat_w_last, unused_sat_r_ready, unused_sat_b_ready;
    logic         unused_sat_out_valid;
    logic [32:0]  unused_sat_ar_addr, unused_sat_aw_addr;
    logic [3:0]   unused_sat_ar_len, unused_sat_ar_cache, unused_sat_ar_qos, unused_sat_ar_region;
    logic [3:0]   unused_sat_aw_len, unused_sat_aw_cache, unused_sat_aw_qos, unused_sat_aw_region;
    logic [2:0]   unused_sat_ar_size, unused_sat_ar_prot, unused_sat_aw_size, unused_sat_aw_prot;
    logic [1:0]   unused_sat_ar_burst, unused_sat_aw_burst;
    logic [5:0]   unused_sat_ar_id, unused_sat_aw_id;
    logic [31:0]  unused_sat_w_strb;

    vector_add_acc #(.SAT(0)) u_dut (
        .clock(clock), .reset(reset),
        .io_infor_in_valid(in_valid), .io_infor_in_ready(in_ready),
        .io_infor_in_bits_addr_read(addr_read), .io_infor_in_bits_len_read(len_read),
        .io_infor_in_bits_addr_write(addr_write), .io_infor_in_bits_len_write(len_write),
        .io_mem_interface_ar_valid(ar_valid), .io_mem_interface_ar_ready(ar_ready),
        .io_mem_interface_ar_addr(ar_addr), .io_mem_interface_ar_len(ar_len),
        .io_mem_interface_ar_size(ar_size), .io_mem_interface_ar_burst(ar_burst),
        .io_mem_interface_ar_id(ar_id), .io_mem_interface_ar_cache(ar_cache),
        .io_mem_interface_ar_lock(ar_lock), .io_mem_interface_ar_prot(ar_prot),
        .io_mem_interface_ar_qos(ar_qos), .io_mem_interface_ar_region(ar_region),
        .io_mem_interface_aw_valid(aw_valid), .io_mem_interface_aw_ready(aw_ready),
        .io_mem_interface_aw_addr(aw_addr), .io_mem_interface_aw_len(aw_len),
        .io_mem_interface_aw_size(aw_size), .io_mem_interface_aw_burst(aw_burst),
        .io_mem_interface_aw_id(aw_id), .io_mem_interface_aw_cache(aw_cache),
        .io_mem_interface_aw_lock(aw_lock), .io_mem_interface_aw_prot(aw_prot),
        .io_mem_interface_aw_qos(aw_qos), .io_mem_interface_aw_region(aw_region),
        .io_mem_interface_w_valid(w_valid), .io_mem_interface_w_ready(w_ready),
        .io_mem_interface_w_data(w_data), .io_mem_interface_w_strb(w_strb),
        .io_mem_interface_w_last(w_last),
        .io_mem_interface_r_valid(r_valid), .io_mem_interface_r_ready(r_ready),
        .io_mem_interface_r_data(r_data), .io_mem_interface_r_last(r_last),
        .io_mem_interface_r_resp(r_resp), .io_mem_interface_r_id(6'd0),
        .io_mem_interface_b_valid(b_valid), .io_mem_interface_b_ready(b_ready),
        .io_mem_interface_b_resp(b_resp), .io_mem_interface_b_id(6'd0),
        .io_infor_out_valid(out_valid), .io_infor_out_ready(out_ready),
        .io_infor_out_bits(out_bits)
    );

    vector_add_acc #(.SAT(1)) u_dut_sat (
        .clock(clock), .reset(reset),
        .io_infor_in_valid(in_valid), .io_infor_in_ready(unused_sat_in_ready),
        .io_infor_in_bits_addr_read(addr_read), .io_infor_in_bits_len_read(len_read),
        .io_infor_in_bits_addr_write(addr_write), .io_infor_in_bits_len_write(len_write),
        .io_mem_interface_ar_valid(unused_sat_ar_valid), .io_mem_interface_ar_ready(ar_ready),
        .io_mem_interface_ar_addr(unused_sat_ar_addr), .io_mem_interface_ar_len(unused_sat_ar_len),
        .io_mem_interface_ar_size(unused_sat_ar_size),
        .io_mem_interface_ar_burst(unused_sat_ar_burst),
        .io_mem_interface_ar_id(unused_sat_ar_id), .io_mem_interface_ar_cache(unused_sat_ar_cache),
        .io_mem_interface_ar_lock(unused_sat_ar_lock), .io_mem_interface_ar_prot(unused_sat_ar_prot),
        .io_mem_interface_ar_qos(unused_sat_ar_qos),
        .io_mem_interface_ar_region(unused_sat_ar_region),
        .io_mem_interface_aw_valid(unused_sat_aw_valid), .io_mem_interface_aw_ready(aw_ready),
        .io_mem_interface_aw_addr(unused_sat_aw_addr), .io_mem_interface_aw_len(unused_sat_aw_len),
        .io_mem_interface_aw_size(unused_sat_aw_size),
        .io_mem_interface_aw_burst(unused_sat_aw_burst),
        .io_mem_interface_aw_id(unused_sat_aw_id), .io_mem_interface_aw_cache(unused_sat_aw_cache),
        .io_mem_interface_aw_lock(unused_sat_aw_lock), .io_mem_interface_aw_prot(unused_sat_aw_prot),
        .io_mem_interface_aw_qos(unused_sat_aw_qos),
        .io_mem_interface_aw_region(unused_sat_aw_region),
        .io_mem_interface_w_valid(unused_sat_w_valid), .io_mem_interface_w_ready(w_ready),
        .io_mem_interface_w_data(sat_w_data), .io_mem_interface_w_strb(unused_sat_w_strb),
        .io_mem_interface_w_last(unused_sat_w_last),
        .io_mem_interface_r_valid(r_valid), .io_mem_interface_r_ready(unused_sat_r_ready),
        .io_mem_interface_r_data(r_data), .io_mem_interface_r_last(r_last),
        .io_mem_interface_r_resp(r_resp), .io_mem_interface_r_id(6'd0),
        .io_mem_interface_b_valid(b_valid), .io_mem_interface_b_ready(unused_sat_b_ready),
        .io_mem_interface_b_resp(b_resp), .io_mem_interface_b_id(6'd0),
        .io_infor_out_valid(unused_sat_out_valid), .io_infor_out_ready(out_ready),
        .io_infor_out_bits(sat_out_bits)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int t;

    // Directed beat data: beats with index < pat_n use pat[], the rest are random.
    logic [255:0] pat [4];
    int           pat_n = 0;
    logic [32:0]  cap_addr [$];
    int           cap_len  [$];
    logic [255:0] last_w_data, last_sat_w_data;
    logic [31:0]  last_w_strb;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    `define WAIT_HI(sig, tag) \
        t = 0; \
        while (!(sig) && t < LIMIT) begin @(negedge clock); t++; end \
        chk(tag, 256'(sig), 256'(1));

    // Issue one command and play the AXI slave; all expectations come from
    // plain arithmetic on the command and the beats the bench supplies.
    task automatic run_cmd(input logic [32:0] ar, input int unsigned lr,
                           input logic [32:0] aw, input int unsigned lw,
                           input int err_beat, input bit b_err);
        longint unsigned addr, rem, page, b, s;
        logic [255:0]    exp_wrap, exp_sat, d;
        logic [31:0]     exp_strb;
        int              beat_idx;
        bit              ok, saw_aw;
        addr     = longint'(ar) & ~64'd31;
        rem      = (longint'(lr) + 31) / 32;
        exp_wrap = '0;
        exp_sat  = '0;
        beat_idx = 0;
        ok       = 1'b1;
        in_valid   = 1'b1;
        addr_read  = ar;
        len_read   = lr;
        addr_write = aw;
        len_write  = lw;
        `WAIT_HI(in_ready, "in_ready")
        @(negedge clock);
        in_valid = 1'b0;
        while (rem > 0) begin
            page = (4096 - (addr % 4096)) / 32;
            b = rem;
            if (b > 16) b = 16;
            if (b > page) b = page;
            `WAIT_HI(ar_valid, "ar_valid")
            cap_addr.push_back(ar_addr);
            cap_len.push_back(int'(ar_len));
            chk("ar_addr", 256'(ar_addr), 256'(addr[32:0]));
            chk("ar_len", 256'(ar_len), 256'(b - 1));
            chk("ar_attr", 256'({ar_size, ar_burst, ar_id, ar_cache, ar_lock, ar_prot, ar_qos,
                                 ar_region}),
                256'({3'd5, 2'b01, 6'd0, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0}));
            repeat ($urandom_range(0, 2)) @(negedge clock);
            ar_ready = 1'b1;
            @(negedge clock);
            ar_ready = 1'b0;
            for (longint unsigned k = 0; k < b; k++) begin
                if (beat_idx < pat_n) d = pat[beat_idx];
                else for (int l = 0; l < 8; l++) d[l*32 +: 32] = $urandom();
                r_valid = 1'b1;
                r_data  = d;
                r_last  = (k == b - 1);
                r_resp  = (beat_idx == err_beat) ? 2'd2 : 2'd0;
                if (beat_idx == err_beat) ok = 1'b0;
                `WAIT_HI(r_ready, "r_ready")
                for (int l = 0; l < 8; l++) begin
                    s = longint'(exp_wrap[l*32 +: 32]) + longint'(d[l*32 +: 32]);
                    exp_wrap[l*32 +: 32] = s[31:0];
                    s = longint'(exp_sat[l*32 +: 32]) + longint'(d[l*32 +: 32]);
                    exp_sat[l*32 +: 32] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
                end
                @(negedge clock);
                beat_idx++;
            end
            r_valid = 1'b0;
            r_last  = 1'b0;
            r_resp  = 2'd0;
            addr = addr + b * 32;
            rem  = rem - b;
        end
        if (lw != 0) begin
            for (int i = 0; i < 32; i++) exp_strb[i] = (i < lw);
            `WAIT_HI(aw_valid, "aw_valid")
            chk("aw_addr", 256'(aw_addr), 256'(aw & ~33'd31));
            chk("aw_attr", 256'({aw_len, aw_size, aw_burst, aw_id, aw_cache, aw_lock, aw_prot,
                                 aw_qos, aw_region}),
                256'({4'd0, 3'd5, 2'b01, 6'd0, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0}));
            aw_ready = 1'b1;
            @(negedge clock);
            aw_ready = 1'b0;
            `WAIT_HI(w_valid, "w_valid")
            last_w_data     = w_data;
            last_sat_w_data = sat_w_data;
            last_w_strb     = w_strb;
            chk("w_data_wrap", w_data, exp_wrap);
            chk("w_data_sat", sat_w_data, exp_sat);
            chk("w_strb", 256'(w_strb), 256'(exp_strb));
            chk("w_last", 256'(w_last), 256'(1));
            w_ready = 1'b1;
            @(negedge clock);
            w_ready = 1'b0;
            b_valid = 1'b1;
            b_resp  = b_err ? 2'd2 : 2'd0;
            if (b_err) ok = 1'b0;
            `WAIT_HI(b_ready, "b_ready")
            @(negedge clock);
            b_valid = 1'b0;
            b_resp  = 2'd0;
        end
        saw_aw = 1'b0;
        t = 0;
        while (!out_valid && t < LIMIT) begin
            if (aw_valid) saw_aw = 1'b1;
            @(negedge clock);
            t++;
        end
        chk("out_valid", 256'(out_valid), 256'(1));
        if (lw == 0) chk("no_aw", 256'(saw_aw), 256'(0));
        chk("out_bits", 256'(out_bits), 256'(ok));
        chk("out_bits_sat", 256'(sat_out_bits), 256'(ok));
        repeat ($urandom_range(0, 2)) @(negedge clock);
        chk("out_held", 256'(out_valid), 256'(1));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("back_idle", 256'(in_ready), 256'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_lanes;
        int unsigned  lr, lw;
        int           eb;
        reset = 1'b1;
        in_valid = 1'b0; addr_read = '0; len_read = '0; addr_write = '0; len_write = '0;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_last = 1'b0; r_resp = 2'd0;
        b_valid = 1'b0; b_resp = 2'd0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_valids", 256'({ar_valid, aw_valid, w_valid, out_valid, r_ready, b_ready}),
            256'(0));

        // Two beats with lane i = i+1; sum is lane i = 2*(i+1).
        for (int l = 0; l < 8; l++) pat[0][l*32 +: 32] = 32'(l + 1);
        pat[1] = pat[0];
        pat_n  = 2;
        run_cmd(33'h0000_0100, 64, 33'h0000_2000, 64, -1, 1'b0);
        for (int l = 0; l < 8; l++) exp_lanes[l*32 +: 32] = 32'(2 * (l + 1));
        chk("lanes_16_to_2", last_w_data, exp_lanes);
        chk("strb_full", 256'(last_w_strb), 256'(32'hFFFF_FFFF));

        // 32 beats from address 0: two full bursts.
        pat_n = 0;
        cap_addr.delete(); cap_len.delete();
        run_cmd(33'h0, 1024, 33'h40, 32, -1, 1'b0);
        chk("two_bursts", 256'(cap_addr.size()), 256'(2));
        if (cap_addr.size() == 2) begin
            chk("burst0_addr", 256'(cap_addr[0]), 256'(33'h0));
            chk("burst1_addr", 256'(cap_addr[1]), 256'(33'h200));
            chk("burst_lens", 256'({cap_len[0], cap_len[1]}), 256'({32'd15, 32'd15}));
        end

        // 4 KiB page split.
        cap_addr.delete(); cap_len.delete();
        run_cmd(33'h0FC0, 128, 33'h80, 20, -1, 1'b0);
        chk("split_bursts", 256'(cap_addr.size()), 256'(2));
        if (cap_addr.size() == 2) begin
            chk("split0_addr", 256'(cap_addr[0]), 256'(33'hFC0));
            chk("split1_addr", 256'(cap_addr[1]), 256'(33'h1000));
            chk("split_lens", 256'({cap_len[0], cap_len[1]}), 256'({32'd1, 32'd1}));
        end

        // Saturating vs wrapping lanes.
        for (int l = 0; l < 8; l++) begin
            pat[0][l*32 +: 32] = 32'hFFFF_FFF0;
            pat[1][l*32 +: 32] = 32'h0000_0020;
        end
        pat_n = 2;
        run_cmd(33'h3000, 64, 33'h4000, 64, -1, 1'b0);
        chk("wrap_lane0", 256'(last_w_data[31:0]), 256'(32'h0000_0010));
        chk("sat_lane7", 256'(last_sat_w_data[255:224]), 256'(32'hFFFF_FFFF));
        pat_n = 0;

        // Error response on one read beat; then a read-only command.
        run_cmd(33'h5000, 64, 33'h6000, 64, 1, 1'b0);
        run_cmd(33'h7000, 96, 33'h8000, 0, -1, 1'b0);
        // Write error, and a zero-length read.
        run_cmd(33'h9000, 32, 33'hA000, 8, -1, 1'b1);
        run_cmd(33'hB000, 0, 33'hC000, 40, -1, 1'b0);

        // Reset while in the read data phase.
        in_valid = 1'b1; addr_read = 33'h100; len_read = 256;
        addr_write = 33'h40; len_write = 32;
        `WAIT_HI(in_ready, "rst_test_in")
        @(negedge clock);
        in_valid = 1'b0;
        `WAIT_HI(ar_valid, "rst_test_ar")
        ar_ready = 1'b1;
        @(negedge clock);
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = {8{32'h1234_5678}}; r_last = 1'b0;
        `WAIT_HI(r_ready, "rst_test_r")
        @(negedge clock);
        chk("pre_rst_rdata", 256'(r_ready), 256'(1));
        reset = 1'b1; r_valid = 1'b0;
        @(negedge clock);
        chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
        chk("mid_rst_valids", 256'({ar_valid, aw_valid, w_valid, out_valid, r_ready, b_ready}),
            256'(0));
        reset = 1'b0;
        @(negedge clock);
        run_cmd(33'h2_0000_0000, 200, 33'h1_0000_0020, 33, -1, 1'b0);

        // Randomised commands.
        for (int n = 0; n < 10; n++) begin
            lr = $urandom_range(0, 700);
            lw = $urandom_range(0, 40);
            eb = ($urandom_range(0, 3) == 0 && lr > 0) ? int'($urandom_range(0, (lr + 31) / 32 - 1))
                                                       : -1;
            run_cmd({1'($urandom_range(0, 1)), 32'($urandom())}, lr,
                    {1'($urandom_range(0, 1)), 32'($urandom())}, lw, eb,
                    ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
